card_draw_scheduler: RTL and testbench

Parametrised draw scheduler between N card-drawing objects and the single VGA adapter write port. Each object raises a redraw request, for example when a card flips. The scheduler queues requests in a pending set and serves them round-robin, issuing one `go` pulse at a time. While an object draws, it routes that object's pixel-write stream to the adapter. It replaces the fixed "draw all 16 in order on keypress" sequencer with selective per-card redraws, arbitrary object counts and a hung-object watchdog.

---
 rtl/card_pkg.sv | 32 +++
 rtl/rr_picker.sv | 34 +++
 rtl/card_draw_scheduler.sv | 139 +++++++++++++
 tb/tb_card_draw_scheduler.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/card_pkg.sv
// Shared types and constants for the card drawing blocks: draw FSM encoding,
// default VGA geometry and width helpers.
package card_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_WAIT   = 2'd2
   } draw_state_t;

   localparam int COLOR_DEPTH = 6;
   localparam int X_W         = 10;
   localparam int Y_W         = 9;

   function automatic int clog2(input int value);
      int res;
      int v;
      res = 0;
      v   = value - 1;
      while (v > 0) begin
         res++;
         v = v >> 1;
      end
      return res;
   endfunction

   // Index width that stays at least one bit wide for tiny counts.
   function automatic int idx_width(input int value);
      return (clog2(value) > 1) ? clog2(value) : 1;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping back to bit 0.
module rr_picker
#(
   parameter  int N     = 16,
   localparam int IDX_W = card_pkg::idx_width(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic             valid,
   output logic [IDX_W-1:0] sel
);

   localparam int             IDX_W1 = IDX_W + 1;
   localparam logic [IDX_W:0] N_EXT  = IDX_W1'(N);

   logic [N-1:0]     rot;
   logic [IDX_W-1:0] enc;
   logic [IDX_W:0]   sum;

   always_comb begin
      // Rotate so that bit ptr lands at position 0, then take the lowest set bit.
      rot   = N'({req, req} >> ptr);
      valid = |req;
      enc   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) enc = IDX_W'(i);
      end
      sum = {1'b0, enc} + {1'b0, ptr};
      if (sum >= N_EXT) sum = sum - N_EXT;
      sel = sum[IDX_W-1:0];
   end

endmodule

// File: rtl/card_draw_scheduler.sv
// Draw scheduler: queues per-object redraw requests, launches one object at a
// time in round-robin order and muxes its pixel stream onto the VGA port.
//
// state  | meaning
// IDLE   | nothing drawing; launch the next pending object if any
// LAUNCH | one-cycle go pulse to cur_idx, watchdog cleared
// WAIT   | object drawing; leave on its done or on watchdog expiry
module card_draw_scheduler
#(
   parameter  int N_OBJ       = 16,
   parameter  int COLOR_DEPTH = card_pkg::COLOR_DEPTH,
   parameter  int X_W         = card_pkg::X_W,
   parameter  int Y_W         = card_pkg::Y_W,
   parameter  int TIMEOUT     = 65536,
   localparam int IDX_W       = card_pkg::idx_width(N_OBJ)
) (
   input  logic                         Clock,
   input  logic                         Reset,
   input  logic [N_OBJ-1:0]             redraw_req,
   input  logic                         redraw_all,
   output logic [N_OBJ-1:0]             obj_go,
   input  logic [N_OBJ-1:0]             obj_done,
   input  logic [N_OBJ-1:0]             obj_write,
   input  logic [N_OBJ*X_W-1:0]         obj_x_bus,
   input  logic [N_OBJ*Y_W-1:0]         obj_y_bus,
   input  logic [N_OBJ*COLOR_DEPTH-1:0] obj_color_bus,
   output logic [X_W-1:0]               vga_x,
   output logic [Y_W-1:0]               vga_y,
   output logic [COLOR_DEPTH-1:0]       vga_color,
   output logic                         vga_write,
   output logic                         busy,
   output logic [IDX_W-1:0]             cur_idx,
   output logic [N_OBJ-1:0]             pending,
   output logic                         timeout_err
);

   import card_pkg::*;

   localparam int WD_W = idx_width(TIMEOUT);

   draw_state_t      state, state_nxt;
   logic [N_OBJ-1:0] pending_q;
   logic [N_OBJ-1:0] launch_clear;
   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] cur_idx_q;
   logic [IDX_W-1:0] next_ptr;
   logic [IDX_W-1:0] pick_ptr;
   logic [IDX_W-1:0] sel;
   logic             pick_valid;
   logic [WD_W-1:0]  wd_cnt;
   logic             done_cur;
   logic             wd_expired;
   logic             finish;
   logic             take;

   assign done_cur   = obj_done[cur_idx_q];
   assign wd_expired = (wd_cnt == WD_W'(TIMEOUT - 1));
   assign finish     = (state == ST_WAIT) && (done_cur || wd_expired);
   assign next_ptr   = (cur_idx_q == IDX_W'(N_OBJ - 1)) ? '0 : cur_idx_q + 1'b1;

   // On a finishing cycle the pick already uses the advanced pointer so the
   // back-to-back launch follows the just-served object.
   assign pick_ptr = finish ? next_ptr : rr_ptr;

   rr_picker #(
      .N (N_OBJ)
   ) u_picker (
      .req   (pending_q),
      .ptr   (pick_ptr),
      .valid (pick_valid),
      .sel   (sel)
   );

   always_comb begin
      state_nxt = state;
      take      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (pick_valid) begin
               take      = 1'b1;
               state_nxt = ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (finish) begin
               if (pick_valid) begin
                  take      = 1'b1;
                  state_nxt = ST_LAUNCH;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   assign launch_clear = take ? (N_OBJ'(1) << sel) : '0;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state     <= ST_IDLE;
         pending_q <= '0;
         rr_ptr    <= '0;
         cur_idx_q <= '0;
         wd_cnt    <= '0;
      end else begin
         state     <= state_nxt;
         // A set in the same cycle as the clear of that bit wins.
         pending_q <= (pending_q & ~launch_clear) | redraw_req | {N_OBJ{redraw_all}};
         if (take) cur_idx_q <= sel;
         if (finish) rr_ptr <= next_ptr;
         if (state == ST_LAUNCH) begin
            wd_cnt <= '0;
         end else if ((state == ST_WAIT) && !wd_expired) begin
            wd_cnt <= wd_cnt + 1'b1;
         end
      end
   end

   assign obj_go      = (state == ST_LAUNCH) ? (N_OBJ'(1) << cur_idx_q) : '0;
   assign busy        = (state != ST_IDLE);
   assign timeout_err = (state == ST_WAIT) && wd_expired && !done_cur;
   assign cur_idx     = cur_idx_q;
   assign pending     = pending_q;

   always_comb begin
      vga_x     = obj_x_bus[cur_idx_q*X_W +: X_W];
      vga_y     = obj_y_bus[cur_idx_q*Y_W +: Y_W];
      vga_color = obj_color_bus[cur_idx_q*COLOR_DEPTH +: COLOR_DEPTH];
      vga_write = (state != ST_IDLE) ? obj_write[cur_idx_q] : 1'b0;
   end

endmodule

// File: tb/tb_card_draw_scheduler.sv
// Self-checking bench for card_draw_scheduler: directed scenarios followed by
// random traffic, every cycle compared against a behavioural model.
module tb_card_draw_scheduler;

   localparam int NB  = 16;
   localparam int TMO = 8;
   localparam int CD  = 6;
   localparam int XW  = 10;
   localparam int YW  = 9;
   localparam int IW  = 4;

   logic              Clock = 1'b0;
   logic              Reset;
   logic [NB-1:0]     redraw_req;
   logic              redraw_all;
   logic [NB-1:0]     obj_go;
   logic [NB-1:0]     obj_done;
   logic [NB-1:0]     obj_write;
   logic [NB*XW-1:0]  obj_x_bus;
   logic [NB*YW-1:0]  obj_y_bus;
   logic [NB*CD-1:0]  obj_color_bus;
   logic [XW-1:0]     vga_x;
   logic [YW-1:0]     vga_y;
   logic [CD-1:0]     vga_color;
   logic              vga_write;
   logic              busy;
   logic [IW-1:0]     cur_idx;
   logic [NB-1:0]     pending;
   logic              timeout_err;

   always #5 Clock = ~Clock;

   card_draw_scheduler #(
      .N_OBJ       (NB),
      .COLOR_DEPTH (CD),
      .X_W         (XW),
      .Y_W         (YW),
      .TIMEOUT     (TMO)
   ) dut (
      .Clock         (Clock),
      .Reset         (Reset),
      .redraw_req    (redraw_req),
      .redraw_all    (redraw_all),
      .obj_go        (obj_go),
      .obj_done      (obj_done),
      .obj_write     (obj_write),
      .obj_x_bus     (obj_x_bus),
      .obj_y_bus     (obj_y_bus),
      .obj_color_bus (obj_color_bus),
      .vga_x         (vga_x),
      .vga_y         (vga_y),
      .vga_color     (vga_color),
      .vga_write     (vga_write),
      .busy          (busy),
      .cur_idx       (cur_idx),
      .pending       (pending),
      .timeout_err   (timeout_err)
   );

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;

   // Reference model: which object is being served and how many cycles ago
   // its go pulse was issued (age 0 = go cycle, age k = k-th waiting cycle).
   logic [NB-1:0] m_pend;
   int            m_ptr;
   int            m_cur;
   bit            m_active;
   int            m_age;
   int            dlen_cur;
   int            plan [NB];
   bit            rand_plan;
   bit            noise_en;

   int go_log[$];
   int go_cyc[$];
   int terr_cyc[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   task automatic model_reset();
      m_pend   = '0;
      m_ptr    = 0;
      m_cur    = 0;
      m_active = 1'b0;
      m_age    = 0;
      dlen_cur = 0;
   endtask

   task automatic clear_logs();
      go_log.delete();
      go_cyc.delete();
      terr_cyc.delete();
   endtask

   // One clock cycle: drive inputs, compare outputs mid-cycle, advance model.
   task automatic cycle(input logic rst, input logic [NB-1:0] req, input logic all);
      logic [NB-1:0] dn;
      logic [NB-1:0] exp_go;
      logic [NB-1:0] nxt_pend;
      logic          r_req_all;
      logic [NB-1:0] r_req;
      bit            done_now, fin, tmo, launch;
      int            sel;

      r_req     = req;
      r_req_all = all;
      dn        = noise_en ? (NB'($urandom) & ~(NB'(1) << m_cur)) : '0;
      done_now  = m_active && (m_age >= 1) && (dlen_cur != 0) && (m_age == dlen_cur);
      if (done_now) begin
         dn[m_cur] = 1'b1;
         r_req     = '0;
         r_req_all = 1'b0;
      end
      Reset      = rst;
      redraw_req = r_req;
      redraw_all = r_req_all;
      obj_done   = dn;
      obj_write  = NB'($urandom);
      for (int i = 0; i < NB; i++) begin
         obj_x_bus[i*XW +: XW]     = XW'($urandom);
         obj_y_bus[i*YW +: YW]     = YW'($urandom);
         obj_color_bus[i*CD +: CD] = CD'($urandom);
      end

      @(negedge Clock);
      exp_go = (m_active && m_age == 0) ? (NB'(1) << m_cur) : '0;
      fin    = m_active && (m_age >= 1) && (dn[m_cur] || m_age == TMO);
      tmo    = m_active && (m_age >= 1) && !dn[m_cur] && (m_age == TMO);
      chk("busy",        busy,        m_active);
      chk("obj_go",      obj_go,      exp_go);
      chk("timeout_err", timeout_err, tmo);
      chk("cur_idx",     cur_idx,     m_cur);
      chk("pending",     pending,     m_pend);
      chk("vga_write",   vga_write,   m_active ? obj_write[m_cur] : 1'b0);
      chk("vga_x",       vga_x,       obj_x_bus[m_cur*XW +: XW]);
      chk("vga_y",       vga_y,       obj_y_bus[m_cur*YW +: YW]);
      chk("vga_color",   vga_color,   obj_color_bus[m_cur*CD +: CD]);
      for (int i = 0; i < NB; i++) begin
         if (obj_go[i] === 1'b1) begin
            go_log.push_back(i);
            go_cyc.push_back(cyc);
         end
      end
      if (timeout_err === 1'b1) terr_cyc.push_back(cyc);

      if (rst) begin
         model_reset();
      end else begin
         if (fin) m_ptr = (m_cur + 1) % NB;
         launch = (!m_active || fin) && (m_pend != '0);
         sel    = 0;
         for (int k = NB - 1; k >= 0; k--) begin
            if (m_pend[(m_ptr + k) % NB]) sel = (m_ptr + k) % NB;
         end
         nxt_pend = m_pend;
         if (launch) nxt_pend[sel] = 1'b0;
         nxt_pend = nxt_pend | r_req | {NB{r_req_all}};
         if (launch) begin
            m_cur    = sel;
            m_active = 1'b1;
            m_age    = 0;
            dlen_cur = rand_plan ? int'($urandom_range(1, TMO + 1)) : plan[sel];
         end else if (fin) begin
            m_active = 1'b0;
         end else if (m_active) begin
            m_age++;
         end
         m_pend = nxt_pend;
      end

      @(posedge Clock);
      #1;
      cyc++;
   endtask

   task automatic drain(input int max_cycles);
      int n;
      n = 0;
      while ((m_active || m_pend != '0) && n < max_cycles) begin
         cycle(1'b0, '0, 1'b0);
         n++;
      end
      chk("drain_bound", 64'(n >= max_cycles), 64'd0);
   endtask

   task automatic chk_order(input string tag, input int exp_q[$]);
      chk({tag, "_count"}, go_log.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < go_log.size(); i++) begin
         chk(tag, go_log[i], exp_q[i]);
      end
   endtask

   initial begin
      int exp_q[$];
      int t_req;
      logic [NB-1:0] rq;

      rand_plan  = 1'b0;
      noise_en   = 1'b0;
      for (int i = 0; i < NB; i++) plan[i] = 4;
      Reset         = 1'b1;
      redraw_req    = '0;
      redraw_all    = 1'b0;
      obj_done      = '0;
      obj_write     = '0;
      obj_x_bus     = '0;
      obj_y_bus     = '0;
      obj_color_bus = '0;
      repeat (2) @(posedge Clock);
      #1;
      model_reset();
      cycle(1'b1, '0, 1'b0);
      cycle(1'b1, '0, 1'b0);

      // Single request from reset: go two cycles after the request.
      clear_logs();
      t_req = cyc;
      cycle(1'b0, 16'h0001, 1'b0);
      drain(50);
      exp_q = {0};
      chk_order("single_order", exp_q);
      if (go_cyc.size() > 0) chk("single_latency", go_cyc[0] - t_req, 2);

      // redraw_all from reset: 0..15 in order, each go one cycle after done.
      cycle(1'b1, '0, 1'b0);
      clear_logs();
      cycle(1'b0, '0, 1'b1);
      drain(400);
      exp_q.delete();
      for (int i = 0; i < NB; i++) exp_q.push_back(i);
      chk_order("all_order", exp_q);
      for (int i = 1; i < go_cyc.size(); i++) chk("all_gap", go_cyc[i] - go_cyc[i-1], plan[i-1] + 1);
      chk("all_pending_end", pending, 0);

      // Pointer at 5 after serving 4: {2,9} serves 9 first.
      cycle(1'b0, 16'h0010, 1'b0);
      drain(50);
      clear_logs();
      cycle(1'b0, 16'h0204, 1'b0);
      drain(50);
      exp_q = {9, 2};
      chk_order("rr_order", exp_q);

      // Re-request of 3 in its own clearing cycle keeps the bit set.
      clear_logs();
      cycle(1'b0, 16'h0008, 1'b0);
      cycle(1'b0, 16'h0008, 1'b0);
      chk("pend3_kept", pending[3], 1'b1);
      drain(50);
      exp_q = {3, 3};
      chk_order("rereq_order", exp_q);

      // Hung object 6: watchdog pulse on the TIMEOUT-th waiting cycle, then 7.
      plan[6] = 0;
      clear_logs();
      cycle(1'b0, 16'h00C0, 1'b0);
      drain(100);
      exp_q = {6, 7};
      chk_order("tmo_order", exp_q);
      chk("tmo_pulses", terr_cyc.size(), 1);
      if (terr_cyc.size() > 0 && go_cyc.size() > 0) chk("tmo_latency", terr_cyc[0] - go_cyc[0], TMO);
      plan[6] = 4;

      // Reset in the middle of drawing object 10 with another request queued.
      clear_logs();
      cycle(1'b0, 16'h0400, 1'b0);
      cycle(1'b0, '0, 1'b0);
      cycle(1'b0, '0, 1'b0);
      cycle(1'b0, 16'h1000, 1'b0);
      cycle(1'b1, 16'h1000, 1'b0);
      chk("rst_busy",      busy,      1'b0);
      chk("rst_pending",   pending,   '0);
      chk("rst_vga_write", vga_write, 1'b0);
      chk("rst_obj_go",    obj_go,    '0);
      cycle(1'b0, '0, 1'b0);

      // Random traffic with random draw lengths, stray done strobes and resets.
      rand_plan = 1'b1;
      noise_en  = 1'b1;
      for (int n = 0; n < 1500; n++) begin
         rq = '0;
         if ($urandom_range(0, 5) == 0) rq[$urandom_range(0, NB - 1)] = 1'b1;
         if ($urandom_range(0, 15) == 0) rq[$urandom_range(0, NB - 1)] = 1'b1;
         cycle(($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0, rq, ($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0);
      end
      drain(600);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
